// File: rtl/uart_xcvr_if.sv
// -----------------------------------------------------------------------------
// uart_xcvr_if
// Bundles the serial line and byte-level handshake of the 8N1 UART transceiver.
//   uart_rxd       serial input (asynchronous to the system clock)
//   uart_txd       serial output, idle high
//   uart_done      one-cycle strobe, uart_data_out holds a new byte
//   uart_data_out  last byte received with a good stop bit
//   frame_err      one-cycle strobe, stop bit sampled low
//   uart_en        transmit request, acted on at its rising edge
//   uart_data_in   byte to transmit
//   tx_busy        transmitter occupied with a frame
// Modports:
//   slave   the transceiver itself
//   master  whatever drives requests / the serial input and consumes results
// -----------------------------------------------------------------------------
interface uart_xcvr_if;
  logic       uart_rxd;
  logic       uart_txd;
  logic       uart_done;
  logic [7:0] uart_data_out;
  logic       frame_err;
  logic       uart_en;
  logic [7:0] uart_data_in;
  logic       tx_busy;

  modport slave (
    input  uart_rxd,
    input  uart_en,
    input  uart_data_in,
    output uart_txd,
    output uart_done,
    output uart_data_out,
    output frame_err,
    output tx_busy
  );

  modport master (
    output uart_rxd,
    output uart_en,
    output uart_data_in,
    input  uart_txd,
    input  uart_done,
    input  uart_data_out,
    input  frame_err,
    input  tx_busy
  );
endinterface

// File: rtl/uart_xcvr.sv
// -----------------------------------------------------------------------------
// uart_xcvr
// 8N1 UART transceiver with independent receive and transmit halves sharing one
// clock. The bit period is DIV = CLK_FREQ / BAUD clock cycles (truncated, and
// expected to be at least 4).
// Ports:
//   sys_clk  system clock, rising edge
//   sys_rst  asynchronous reset, active high
//   bus      uart_xcvr_if.slave: serial line, receive strobes/data, transmit
//            request/data and tx_busy
// Receive: uart_rxd is double-flopped, a start bit is confirmed at its centre,
// eight data bits are sampled LSB first at their centres, and the stop bit
// decides between a uart_done and a frame_err strobe.
// Transmit: a rising edge on uart_en while idle (or in the final stop cycle)
// captures uart_data_in and sends start, 8 data bits LSB first, stop.
// -----------------------------------------------------------------------------
module uart_xcvr #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  uart_xcvr_if.slave bus
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic            rx_meta_q;
  logic            rx_s_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q,   rx_cnt_d;
  logic [2:0]      rx_idx_q,   rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_byte_q,  rx_byte_d;
  logic            rx_done_q,  rx_done_d;
  logic            rx_ferr_q,  rx_ferr_d;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.uart_rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= CNT_ZERO;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_done_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_done_q  <= rx_done_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Receive next-state logic: half-bit start check, then full-bit steps so
  // every later sample lands at a bit centre.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_done_d  = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = CNT_ZERO;
        if (!rx_s_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = CNT_ZERO;
          rx_idx_d = 3'd0;
          // A line that is high again at mid start bit was only a glitch.
          if (rx_s_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = CNT_ZERO;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = CNT_ZERO;
          rx_state_d = RX_IDLE;
          if (rx_s_q) begin
            rx_byte_d = rx_shift_q;
            rx_done_d = 1'b1;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign bus.uart_done     = rx_done_q;
  assign bus.frame_err     = rx_ferr_q;
  assign bus.uart_data_out = rx_byte_q;

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  logic            en_q;
  logic            tx_req_s;
  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q,   tx_cnt_d;
  logic [2:0]      tx_idx_q,   tx_idx_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_txd_q,   tx_txd_d;
  logic            tx_busy_q,  tx_busy_d;

  assign tx_req_s = bus.uart_en & ~en_q;

  // Previous uart_en value for rising-edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= bus.uart_en;
    end
  end

  // Transmit FSM state and datapath registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= CNT_ZERO;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_txd_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_txd_q   <= tx_txd_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Transmit next-state logic. txd is registered, so each line value is
  // computed one cycle ahead, at the edge that ends the previous bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_txd_d   = tx_txd_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_txd_d = 1'b1;
        if (tx_req_s) begin
          tx_shift_d = bus.uart_data_in;
          tx_busy_d  = 1'b1;
          tx_cnt_d   = CNT_ZERO;
          tx_txd_d   = 1'b0;
          tx_state_d = TX_START;
        end else begin
          tx_busy_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = CNT_ZERO;
          tx_idx_d   = 3'd0;
          tx_txd_d   = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = CNT_ZERO;
          if (tx_idx_q == 3'd7) begin
            tx_txd_d   = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = {1'b1, tx_shift_q[7:1]};
            tx_txd_d   = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = CNT_ZERO;
          // A request seen as the stop bit ends chains the next frame with
          // no idle gap; tx_busy then simply stays high.
          if (tx_req_s) begin
            tx_shift_d = bus.uart_data_in;
            tx_busy_d  = 1'b1;
            tx_txd_d   = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_busy_d  = 1'b0;
            tx_txd_d   = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = CNT_ZERO;
        tx_txd_d   = 1'b1;
        tx_busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.uart_txd = tx_txd_q;
  assign bus.tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// -----------------------------------------------------------------------------
// tb_uart_xcvr
// Scoreboard bench for uart_xcvr with CLK_FREQ=1000, BAUD=100 (10 cycles/bit).
// Stimulus pushes expected receive events and transmit bytes into queues; two
// monitors (strobe watcher and a serial line decoder) pop and compare.
// -----------------------------------------------------------------------------
module tb_uart_xcvr;
  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DIV      = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_drv = 1'b1;
  logic loopback = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Receive expectations: {is_frame_error, expected uart_data_out}.
  logic [8:0] rx_q[$];
  // Bytes expected to appear on the serial output, in order.
  logic [7:0] tx_q[$];
  // Reference value of uart_data_out: last byte with a good stop bit.
  logic [7:0] last_good = 8'h00;

  // Line decoder state.
  logic       tm_busy = 1'b0;
  int         tm_cnt  = 0;
  logic [7:0] tm_bits = 8'h00;

  uart_xcvr_if u_if();

  assign u_if.uart_rxd = loopback ? u_if.uart_txd : rxd_drv;

  uart_xcvr #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Which bit of a frame (0 = start .. 9 = stop) has its centre at sample c
  // counted from the first low sample; -1 if none.
  function automatic int bit_slot(input int c);
    if (c >= DIV / 2 && ((c - DIV / 2) % DIV) == 0) begin
      return (c - DIV / 2) / DIV;
    end else begin
      return -1;
    end
  endfunction

  // Receive monitor: every strobe cycle must match the next expectation.
  always @(negedge clk) begin
    if (!rst && (u_if.uart_done || u_if.frame_err)) begin
      check("rx_expected_event", 32'(rx_q.size() != 0), 32'd1);
      if (rx_q.size() != 0) begin
        check("rx_done",  32'(u_if.uart_done), 32'(!rx_q[0][8]));
        check("rx_ferr",  32'(u_if.frame_err), 32'(rx_q[0][8]));
        check("rx_data",  32'(u_if.uart_data_out), 32'(rx_q[0][7:0]));
        void'(rx_q.pop_front());
      end
    end
  end

  // Serial line decoder: finds a start edge, samples each bit centre.
  always @(negedge clk) begin
    if (rst) begin
      tm_busy <= 1'b0;
      tm_cnt  <= 0;
    end else if (!tm_busy) begin
      if (u_if.uart_txd == 1'b0) begin
        tm_busy <= 1'b1;
        tm_cnt  <= 1;
      end
    end else begin
      tm_cnt <= tm_cnt + 1;
      if (bit_slot(tm_cnt) == 0) begin
        check("tx_start_bit", 32'(u_if.uart_txd), 32'd0);
      end else if (bit_slot(tm_cnt) >= 1 && bit_slot(tm_cnt) <= 8) begin
        tm_bits[bit_slot(tm_cnt) - 1] <= u_if.uart_txd;
      end else if (bit_slot(tm_cnt) == 9) begin
        tm_busy <= 1'b0;
        check("tx_stop_bit", 32'(u_if.uart_txd), 32'd1);
        check("tx_expected_frame", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) begin
          check("tx_byte", 32'(tm_bits), 32'(tx_q.pop_front()));
        end
      end
    end
  end

  // Sends one frame on rxd and records what the receiver must report.
  task automatic rx_frame(input logic [7:0] b, input logic stop_ok, input int gap);
    logic [9:0] fb;
    fb = {stop_ok, b, 1'b0};
    if (stop_ok) begin
      last_good = b;
      rx_q.push_back({1'b0, b});
    end else begin
      rx_q.push_back({1'b1, last_good});
    end
    for (int k = 0; k < 10; k++) begin
      rxd_drv = fb[k];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // One-cycle uart_en pulse carrying byte d.
  task automatic tx_pulse(input logic [7:0] d);
    u_if.uart_data_in = d;
    u_if.uart_en      = 1'b1;
    @(posedge clk);
    #1;
    u_if.uart_en      = 1'b0;
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 300 && u_if.tx_busy; i++) @(negedge clk);
    check("tx_idle_timeout", 32'(u_if.tx_busy), 32'd0);
  endtask

  initial begin
    logic [9:0] fb;
    logic [7:0] b;
    u_if.uart_en      = 1'b0;
    u_if.uart_data_in = 8'h00;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_txd",      32'(u_if.uart_txd), 32'd1);
    check("rst_done",     32'(u_if.uart_done), 32'd0);
    check("rst_data_out", 32'(u_if.uart_data_out), 32'd0);
    check("rst_ferr",     32'(u_if.frame_err), 32'd0);
    check("rst_busy",     32'(u_if.tx_busy), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Good frame, bad stop bit (data_out held), start glitch, good frame.
    rx_frame(8'hA5, 1'b1, 5);
    rx_frame(8'h3C, 1'b0, 5);
    rxd_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_no_event", 32'(rx_q.size()), 32'd0);
    rx_frame(8'h55, 1'b1, 5);
    check("rx_directed_drained", 32'(rx_q.size()), 32'd0);

    // Exact transmit waveform and busy window for 0x81.
    fb = {1'b1, 8'h81, 1'b0};
    tx_q.push_back(8'h81);
    tx_pulse(8'h81);
    for (int i = 0; i < 10 * DIV; i++) begin
      @(negedge clk);
      check("tx_wave", 32'(u_if.uart_txd), 32'(fb[i / DIV]));
      check("tx_busy_window", 32'(u_if.tx_busy), 32'd1);
    end
    @(negedge clk);
    check("tx_busy_end", 32'(u_if.tx_busy), 32'd0);
    check("tx_idle_line", 32'(u_if.uart_txd), 32'd1);
    repeat (5) @(posedge clk);
    #1;

    // Mid-frame request dropped; request in the last stop cycle chains 0xFF.
    tx_q.push_back(8'h81);
    tx_q.push_back(8'hFF);
    tx_pulse(8'h81);
    for (int i = 0; i < 10 * DIV; i++) begin
      @(negedge clk);
      if (i == 40) begin
        u_if.uart_data_in = 8'hFF;
        u_if.uart_en      = 1'b1;
      end
      if (i == 41) u_if.uart_en = 1'b0;
      if (i == 10 * DIV - 1) u_if.uart_en = 1'b1;
    end
    @(posedge clk);
    #1;
    u_if.uart_en = 1'b0;
    @(negedge clk);
    check("b2b_busy",  32'(u_if.tx_busy), 32'd1);
    check("b2b_start", 32'(u_if.uart_txd), 32'd0);
    wait_tx_idle();

    // uart_en held high for over two frame times sends only one frame.
    @(posedge clk);
    #1;
    tx_q.push_back(8'h3C);
    u_if.uart_data_in = 8'h3C;
    u_if.uart_en      = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    u_if.uart_en = 1'b0;
    @(negedge clk);
    check("held_en_busy", 32'(u_if.tx_busy), 32'd0);
    check("held_en_one_frame", 32'(tx_q.size()), 32'd0);

    // Reset in the middle of a receive and a transmit frame.
    tx_pulse(8'h5A);
    rxd_drv = 1'b0;
    repeat (35) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_txd",  32'(u_if.uart_txd), 32'd1);
    check("midrst_busy", 32'(u_if.tx_busy), 32'd0);
    rxd_drv = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    check("midrst_done",     32'(u_if.uart_done), 32'd0);
    check("midrst_ferr",     32'(u_if.frame_err), 32'd0);
    check("midrst_data_out", 32'(u_if.uart_data_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (DIV * 12) @(posedge clk);
    #1;
    check("midrst_no_events", 32'(rx_q.size() + tx_q.size()), 32'd0);

    // Loopback txd -> rxd after reset.
    loopback = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    last_good = 8'hC3;
    rx_q.push_back({1'b0, 8'hC3});
    tx_q.push_back(8'hC3);
    tx_pulse(8'hC3);
    wait_tx_idle();
    repeat (5) @(posedge clk);
    #1;
    check("loopback_rx", 32'(rx_q.size()), 32'd0);
    loopback = 1'b0;

    // Randomised concurrent receive and transmit traffic.
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          rx_frame(8'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(2, 6));
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          b = 8'($urandom);
          tx_q.push_back(b);
          tx_pulse(b);
          wait_tx_idle();
          repeat ($urandom_range(1, 5)) @(posedge clk);
          #1;
        end
      end
    join

    for (int i = 0; i < 400 && (rx_q.size() != 0 || tx_q.size() != 0); i++) @(negedge clk);
    check("final_rx_drained", 32'(rx_q.size()), 32'd0);
    check("final_tx_drained", 32'(tx_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
